pipe_collision: RTL and testbench



---
 rtl/game_pkg.sv | 27 ++
 rtl/box_overlap.sv | 40 ++++
 rtl/pipe_collision.sv | 141 ++++++++++++++
 tb/tb_pipe_collision.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-domain definitions: state encoding, screen geometry and sprite defaults
// used by the pipe, bird and collision stages.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_PLAY = 3'b010,
        ST_LOST = 3'b100
    } game_state_e;

    localparam int SCREEN_W   = 800;
    localparam int SCREEN_H   = 525;
    localparam int FLOOR_Y    = 480;
    localparam int BIRD_X     = 200;
    localparam int BIRD_SIZE  = 20;
    localparam int PIPE_WIDTH = 60;
    localparam int GAP_HALF   = 60;

    localparam int POS_W  = 10;
    localparam int CALC_W = 11;

    // Hit-run counter saturates so a long collision cannot wrap back below the filter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational bird-vs-pipe rectangle test plus floor test, all in 11-bit unsigned
// so positions near 1023 never wrap when extended by a sprite dimension.
module box_overlap
    import game_pkg::*;
#(
    parameter int BIRD_X     = game_pkg::BIRD_X,
    parameter int BIRD_SIZE  = game_pkg::BIRD_SIZE,
    parameter int PIPE_WIDTH = game_pkg::PIPE_WIDTH,
    parameter int GAP_HALF   = game_pkg::GAP_HALF,
    parameter int FLOOR_Y    = game_pkg::FLOOR_Y
) (
    input  logic [POS_W-1:0] i_bird_y,
    input  logic [POS_W-1:0] i_pipe_x,
    input  logic [POS_W-1:0] i_pipe_y,
    output logic             o_hx,
    output logic             o_hy,
    output logic             o_hf
);

    localparam logic [CALC_W-1:0] L_X_LO = CALC_W'(BIRD_X);
    localparam logic [CALC_W-1:0] L_X_HI = CALC_W'(BIRD_X + BIRD_SIZE);
    localparam logic [CALC_W-1:0] L_PW   = CALC_W'(PIPE_WIDTH);
    localparam logic [CALC_W-1:0] L_GH   = CALC_W'(GAP_HALF);
    localparam logic [CALC_W-1:0] L_BS   = CALC_W'(BIRD_SIZE);
    localparam logic [CALC_W-1:0] L_FY   = CALC_W'(FLOOR_Y);

    logic [CALC_W-1:0] w_by;
    logic [CALC_W-1:0] w_px;
    logic [CALC_W-1:0] w_py;

    assign w_by = {1'b0, i_bird_y};
    assign w_px = {1'b0, i_pipe_x};
    assign w_py = {1'b0, i_pipe_y};

    assign o_hx = (w_px < L_X_HI) && ((w_px + L_PW) > L_X_LO);
    // Gap-top test moved to the left side to avoid subtracting from the gap centre.
    assign o_hy = ((w_by + L_GH) < w_py) || ((w_by + L_BS) > (w_py + L_GH));
    assign o_hf = (w_by + L_BS) >= L_FY;

endmodule

// File: rtl/pipe_collision.sv
// Collision detection, game-state FSM and pipe-clear scoring, downstream of the pipe mover.
// Inputs are registered, then the hit is registered, then filtered before raising Lost.
module pipe_collision
    import game_pkg::*;
#(
    parameter int BIRD_X     = game_pkg::BIRD_X,
    parameter int BIRD_SIZE  = game_pkg::BIRD_SIZE,
    parameter int PIPE_WIDTH = game_pkg::PIPE_WIDTH,
    parameter int GAP_HALF   = game_pkg::GAP_HALF,
    parameter int FLOOR_Y    = game_pkg::FLOOR_Y,
    parameter int HIT_FILTER = 1,
    parameter int SCORE_W    = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [9:0]         BirdPosY,
    input  logic [9:0]         PipePosX,
    input  logic [9:0]         PipePosY,
    output logic               Lost,
    output logic [SCORE_W-1:0] Score,
    output logic               ScorePulse,
    output logic               Playing
);

    localparam logic [3:0]         L_FILT      = 4'(HIT_FILTER);
    localparam logic [CALC_W-1:0]  L_BX        = CALC_W'(BIRD_X);
    localparam logic [CALC_W-1:0]  L_BX_END    = CALC_W'(BIRD_X + BIRD_SIZE);
    localparam logic [CALC_W-1:0]  L_PW        = CALC_W'(PIPE_WIDTH);
    localparam logic [SCORE_W-1:0] L_SCORE_MAX = '1;

    logic [POS_W-1:0]   r_bird_y;
    logic [POS_W-1:0]   r_pipe_x;
    logic [POS_W-1:0]   r_pipe_y;
    logic               r_hit;
    logic [3:0]         r_cnt;
    logic               r_passed;
    game_state_e        r_state;

    logic               w_hx;
    logic               w_hy;
    logic               w_hf;
    logic [3:0]         w_cnt_nxt;
    logic               w_lose;
    logic               w_cleared;
    logic               w_respawn;
    logic [SCORE_W-1:0] w_score_inc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_bird_y <= '0;
            r_pipe_x <= '0;
            r_pipe_y <= '0;
            r_hit    <= 1'b0;
        end else begin
            r_bird_y <= BirdPosY;
            r_pipe_x <= PipePosX;
            r_pipe_y <= PipePosY;
            r_hit    <= (w_hx && w_hy) || w_hf;
        end
    end

    box_overlap #(
        .BIRD_X     (BIRD_X),
        .BIRD_SIZE  (BIRD_SIZE),
        .PIPE_WIDTH (PIPE_WIDTH),
        .GAP_HALF   (GAP_HALF),
        .FLOOR_Y    (FLOOR_Y)
    ) u_box (
        .i_bird_y (r_bird_y),
        .i_pipe_x (r_pipe_x),
        .i_pipe_y (r_pipe_y),
        .o_hx     (w_hx),
        .o_hy     (w_hy),
        .o_hf     (w_hf)
    );

    // Lost fires on the edge that would bring the run count up to the filter length.
    assign w_cnt_nxt   = sat_inc4(r_cnt);
    assign w_lose      = r_hit && (w_cnt_nxt >= L_FILT);
    assign w_cleared   = ({1'b0, r_pipe_x} + L_PW) <= L_BX;
    assign w_respawn   = {1'b0, r_pipe_x} >= L_BX_END;
    assign w_score_inc = (Score == L_SCORE_MAX) ? Score : Score + 1'b1;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_passed   <= 1'b0;
            Lost       <= 1'b0;
            Score      <= '0;
            ScorePulse <= 1'b0;
            Playing    <= 1'b0;
        end else begin
            ScorePulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 4'd0;
                    Lost  <= 1'b0;
                    if (Start) begin
                        r_state  <= ST_PLAY;
                        Playing  <= 1'b1;
                        Score    <= '0;
                        r_passed <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (w_lose) begin
                        r_state <= ST_LOST;
                        Lost    <= 1'b1;
                        Playing <= 1'b0;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_hit ? w_cnt_nxt : 4'd0;
                        if (!r_passed && w_cleared) begin
                            r_passed   <= 1'b1;
                            Score      <= w_score_inc;
                            ScorePulse <= 1'b1;
                        end else if (w_respawn) begin
                            r_passed <= 1'b0;
                        end
                    end
                end
                ST_LOST: begin
                    r_cnt <= 4'd0;
                    if (Start) begin
                        r_state <= ST_IDLE;
                        Lost    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    Lost    <= 1'b0;
                    Playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_collision.sv
// Randomized + directed bench: two DUTs (filter 1 and 3) share inputs; a game-level
// reference model predicts outputs per edge into queues, a monitor compares on negedge.
module tb_pipe_collision;

    localparam int BX = 200, BS = 20, PW = 60, GH = 60, FY = 480;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [9:0] BirdPosY = 10'd240;
    logic [9:0] PipePosX = 10'd700;
    logic [9:0] PipePosY = 10'd250;

    logic       lost1, pls1, ply1;
    logic [7:0] sc1;
    logic       lost3, pls3, ply3;
    logic [7:0] sc3;

    int errors = 0;
    int checks = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];

    always #5 Clk = ~Clk;

    pipe_collision #(.HIT_FILTER(1)) u_f1 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BirdPosY(BirdPosY),
        .PipePosX(PipePosX), .PipePosY(PipePosY), .Lost(lost1),
        .Score(sc1), .ScorePulse(pls1), .Playing(ply1)
    );

    pipe_collision #(.HIT_FILTER(3)) u_f3 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BirdPosY(BirdPosY),
        .PipePosX(PipePosX), .PipePosY(PipePosY), .Lost(lost3),
        .Score(sc3), .ScorePulse(pls3), .Playing(ply3)
    );

    function automatic bit geo_hit(input int by, input int px, input int py);
        bit hx, hy, hf;
        hx = (px < BX + BS) && (px + PW > BX);
        hy = (by + GH < py) || (by + BS > py + GH);
        hf = (by + BS >= FY);
        return (hx && hy) || hf;
    endfunction

    // Reference model: game state 0=idle 1=play 2=lost; run = consecutive hit edges.
    int m_gs[2], m_run[2], m_score[2], m_pass[2];
    int h1_by, h1_px, h1_py, h2_by, h2_px, h2_py;

    initial begin
        bit          hit, pulse;
        int          filt, run_n;
        logic [10:0] e;
        for (int i = 0; i < 2; i++) begin
            m_gs[i] = 0; m_run[i] = 0; m_score[i] = 0; m_pass[i] = 0;
        end
        h1_by = 0; h1_px = 0; h1_py = 0; h2_by = 0; h2_px = 0; h2_py = 0;
        forever begin
            @(posedge Clk);
            hit = geo_hit(h2_by, h2_px, h2_py);
            for (int i = 0; i < 2; i++) begin
                filt  = (i == 0) ? 1 : 3;
                pulse = 1'b0;
                if (!Reset) begin
                    m_gs[i] = 0; m_run[i] = 0; m_score[i] = 0; m_pass[i] = 0;
                end else begin
                    case (m_gs[i])
                        0: begin
                            m_run[i] = 0;
                            if (Start) begin m_gs[i] = 1; m_score[i] = 0; m_pass[i] = 0; end
                        end
                        1: begin
                            run_n = hit ? ((m_run[i] < 15) ? m_run[i] + 1 : 15) : 0;
                            if (hit && run_n >= filt) begin
                                m_gs[i] = 2; m_run[i] = 0;
                            end else begin
                                m_run[i] = run_n;
                                if (m_pass[i] == 0 && h1_px + PW <= BX) begin
                                    m_pass[i] = 1;
                                    if (m_score[i] < 255) m_score[i]++;
                                    pulse = 1'b1;
                                end else if (h1_px >= BX + BS) begin
                                    m_pass[i] = 0;
                                end
                            end
                        end
                        default: begin
                            m_run[i] = 0;
                            if (Start) m_gs[i] = 0;
                        end
                    endcase
                end
                e = {m_gs[i] == 2, m_gs[i] == 1, pulse, 8'(m_score[i])};
                if (i == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (!Reset) begin
                h1_by = 0; h1_px = 0; h1_py = 0; h2_by = 0; h2_px = 0; h2_py = 0;
            end else begin
                h2_by = h1_by; h2_px = h1_px; h2_py = h1_py;
                h1_by = int'(BirdPosY); h1_px = int'(PipePosX); h1_py = int'(PipePosY);
            end
        end
    end

    // Monitor: outputs are presented every cycle; compare each against the queued prediction.
    initial begin
        logic [10:0] e, g;
        forever begin
            @(negedge Clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                g = {lost1, ply1, pls1, sc1};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL f1_outputs t=%0t got lost/play/pulse/score=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                             $time, g[10], g[9], g[8], g[7:0], e[10], e[9], e[8], e[7:0]);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                g = {lost3, ply3, pls3, sc3};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL f3_outputs t=%0t got lost/play/pulse/score=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
                             $time, g[10], g[9], g[8], g[7:0], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    task automatic drive(input int by, input int px, input int py, input bit st);
        @(negedge Clk);
        BirdPosY = 10'(by);
        PipePosX = 10'(px);
        PipePosY = 10'(py);
        Start    = st;
    endtask

    task automatic safe(input int n);
        for (int k = 0; k < n; k++) drive(240, 700, 250, 1'b0);
    endtask

    // From LOST (or IDLE) back into PLAY with score cleared.
    task automatic restart();
        drive(240, 700, 250, 1'b1);
        drive(240, 700, 250, 1'b0);
        drive(240, 700, 250, 1'b1);
        safe(2);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        Reset = 1'b1;

        // Sweep a pipe past the bird through the gap: one increment at px=140.
        drive(240, 700, 250, 1'b1);
        safe(1);
        for (int x = 300; x >= 100; x -= 4) drive(240, x, 250, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(240, 700, 250, 1'b0);
            drive(240, 100, 250, 1'b0);
        end
        safe(2);

        // Asynchronous reset mid-game with score 5.
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({lost1, ply1, pls1, sc1} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset_f1 got=%h exp=000", {lost1, ply1, pls1, sc1});
        end
        checks++;
        if ({lost3, ply3, pls3, sc3} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset_f3 got=%h exp=000", {lost3, ply3, pls3, sc3});
        end
        @(negedge Clk);
        Reset = 1'b1;

        // Pipe body hit, then Start while still colliding, then restart.
        drive(240, 700, 250, 1'b1);
        safe(2);
        for (int k = 0; k < 6; k++) drive(100, 210, 250, 1'b0);
        drive(100, 210, 250, 1'b1);
        drive(100, 210, 250, 1'b0);
        drive(240, 700, 250, 1'b1);
        safe(3);

        // Floor contact.
        for (int k = 0; k < 6; k++) drive(465, 700, 250, 1'b0);
        restart();

        // Short hit pulses: 2 cycles trips filter 1 only, 3 cycles trips filter 3.
        for (int k = 0; k < 2; k++) drive(465, 700, 250, 1'b0);
        safe(5);
        for (int k = 0; k < 3; k++) drive(465, 700, 250, 1'b0);
        safe(5);
        restart();

        // Hit edge coincides with a clear sample.
        drive(465, 700, 250, 1'b0);
        drive(240, 100, 250, 1'b0);
        safe(4);
        restart();

        // Saturation.
        for (int k = 0; k < 260; k++) begin
            drive(240, 700, 250, 1'b0);
            drive(240, 100, 250, 1'b0);
        end
        restart();

        // X wrap 0 -> 1023 re-arms the scorer without a spurious increment.
        drive(240, 0, 250, 1'b0);
        drive(240, 0, 250, 1'b0);
        drive(240, 1023, 250, 1'b0);
        drive(240, 1023, 250, 1'b0);
        drive(240, 0, 250, 1'b0);
        safe(3);

        // Random play.
        for (int k = 0; k < 800; k++) begin
            int by, px, py;
            by = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 479))
                                             : int'($urandom_range(220, 270));
            px = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1023))
                                             : int'($urandom_range(90, 240));
            py = int'($urandom_range(200, 300));
            drive(by, px, py, $urandom_range(0, 15) == 0);
        end
        safe(4);

        checks++;
        if (q0.size() > 1 || q1.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp<=1", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
